flash_page_writer: RTL and testbench
====================================

Name: flash_page_writer

Overview:
- SPI-mode-0 master that programs one page (1..256 bytes) of the on-board SPI flash.
- Issues Write Enable (0x06), then Page Program (0x02) with a 24-bit address and the data bytes, then polls Read Status (0x05) until WIP clears.
- Write-side counterpart to the flash read path; shares the same flash pins through an external mux owned by the top level.
- Data bytes are pulled from the CPU/loader through a valid/ready handshake.

Parameters:
- CS_HIGH_CYCLES, 8, minimum clk cycles flash_cs held high between transactions (≥1).
- POLL_LIMIT, 32'd2000000, maximum RDSR polls before declaring timeout.

Ports:
- clk  input  1  system clock (27 MHz).
- rst  input  1  synchronous active-low reset.
- strt  input  1  start pulse; sampled only in IDLE.
- addr  input  24  flash byte address of the first byte.
- len  input  9  byte count, 1..256.
- wr_data  input  8  data byte.
- wr_valid  input  1  wr_data valid.
- wr_ready  output  1  block accepts wr_data this cycle.
- busy  output  1  high from the cycle after strt is accepted until done.
- done  output  1  one-cycle pulse at end of operation.
- err  output  1  one-cycle pulse coincident with done on failure.
- flash_clk  output  1  SPI clock, idles low.
- flash_MOSI  output  1  SPI data to flash.
- flash_cs  output  1  chip select, active low.
- flash_MISO  input  1  SPI data from flash.

Behaviour:
- Reset (rst=0 at posedge):
  - Outputs: flash_cs=1, flash_clk=0, flash_MOSI=0, wr_ready=0, busy=0, done=0, err=0.
  - State returns to IDLE; counters clear.
  - Applies mid-transaction: cs deasserts at that edge and the partial page is abandoned.
- Bit engine:
  - Each bit takes 2 clk cycles: low phase (flash_clk=0, MOSI updated with the next bit, MSB first), then high phase (flash_clk=1, MISO sampled).
  - flash_clk returns to 0 on the first cycle after the last bit.
- IDLE:
  - On strt=1, latch addr and len and set busy.
  - strt while busy is ignored.
- CHECK:
  - If len==0, len>256, or addr[7:0]+len>256 (page crossing): pulse err and done; no cs activity.
  - Otherwise go to WREN.
- WREN: cs low, send 8 bits 0x06 (16 cycles), cs high, then GAP.
- GAP: cs high for CS_HIGH_CYCLES, then go to the next transaction.
- PP_HDR: cs low, send 32 bits {0x02, addr} (64 cycles).
- DATA_WAIT:
  - cs stays low, flash_clk held low, wr_ready=1.
  - A transfer occurs on a cycle with wr_valid&&wr_ready; the byte is latched and wr_ready=0 from the next cycle.
  - Stalls indefinitely with no timeout.
- DATA_SEND:
  - Shift the latched byte (16 cycles) and decrement remaining.
  - If remaining≠0, return to DATA_WAIT; else cs high, then GAP.
- RDSR:
  - cs low, send 0x05, read 8 status bits (32 cycles total), cs high, then GAP.
  - Poll count increments per RDSR transaction.
  - status[0]==0: DONE.
  - status[0]==1 and poll count==POLL_LIMIT: pulse err and done, return to IDLE.
  - Otherwise repeat RDSR.
- DONE: done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
- A new strt is accepted the following cycle.
- Exactly len bytes are consumed; wr_ready is never high outside DATA_WAIT.
- CS rule: cs is never low across two commands; every command boundary includes ≥CS_HIGH_CYCLES of cs high.

Test Plan:
- addr=0x000100, len=4, bytes A5,5A,00,FF, flash model WIP clears after 3 polls -> bus shows:
  - 0x06; gap≥8 cycles
  - 0x02,00,01,00,A5,5A,00,FF; gap
  - three RDSR transactions
  - one done pulse, err=0, exactly 4 wr handshakes.
- addr=0x0000F0, len=17 -> err and done pulse 2 cycles after strt; flash_cs stays 1 throughout; wr_ready never asserted.
- len=256, addr[7:0]=0, wr_valid deasserted for 50 cycles before byte 10 -> flash_clk held low and cs low during the stall; all 256 bytes appear on MOSI in order.
- POLL_LIMIT=3, model holds WIP=1 -> exactly 3 RDSR transactions, then err=1 and done=1 in the same cycle.
- rst=0 asserted during PP_HDR bit 20 -> next edge: flash_cs=1, flash_clk=0, busy=0; a subsequent strt runs a clean full sequence.
- strt re-pulsed while busy -> ignored: one done pulse only, addr change has no effect.

Source files
------------

// File: rtl/flash_page_writer.sv
// flash_page_writer: SPI mode-0 master that programs one flash page (WREN, PP, RDSR polling).
// Data bytes arrive over a valid/ready handshake; only a single transaction shifts at a time.
module flash_page_writer #(
  parameter int          CS_HIGH_CYCLES = 8,
  parameter logic [31:0] POLL_LIMIT     = 32'd2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt,
  input  logic [23:0] addr,
  input  logic [8:0]  len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        flash_clk,
  output logic        flash_MOSI,
  output logic        flash_cs,
  input  logic        flash_MISO
);
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SHIFT, S_GAP, S_DWAIT} state_t;
  typedef enum logic [2:0] {OP_WREN, OP_PP, OP_DATA, OP_RDSR, OP_FIN} op_t;
  state_t      r_st;
  op_t         r_op, r_nxt;
  logic [23:0] r_addr;
  logic [8:0]  r_len;
  logic [31:0] r_sr;
  logic [5:0]  r_cnt;
  logic        r_ph;
  logic [15:0] r_gap;
  logic [31:0] r_polls;
  logic        r_tmo, r_cs, r_fclk, r_mosi, r_rdy, r_busy, r_done, r_err;
  op_t         w_op;
  logic [31:0] w_ld;
  logic [5:0]  w_ld_cnt;
  logic [9:0]  w_sum;
  logic        w_bad, w_go;
  logic [31:0] w_poll;
  assign w_op     = (r_st == S_CHECK) ? OP_WREN : (r_st == S_DWAIT) ? OP_DATA : r_nxt;
  assign w_ld     = (w_op == OP_WREN) ? {8'h06, 24'h0} :
                    (w_op == OP_PP)   ? {8'h02, r_addr} :
                    (w_op == OP_DATA) ? {wr_data, 24'h0} : {8'h05, 24'h0};
  assign w_ld_cnt = (w_op == OP_PP) ? 6'd32 : (w_op == OP_RDSR) ? 6'd16 : 6'd8;
  assign w_sum    = {2'b0, r_addr[7:0]} + {1'b0, r_len};
  assign w_bad    = (r_len == 9'd0) || (r_len > 9'd256) || (w_sum > 10'd256);
  assign w_poll   = r_polls + 32'd1;
  // A new transaction (cs low, first bit on MOSI) launches from any of these three points.
  assign w_go     = (r_st == S_CHECK && !w_bad) ||
                    (r_st == S_GAP && r_gap == 16'd0 && r_nxt != OP_FIN) ||
                    (r_st == S_DWAIT && wr_valid && r_rdy);
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_st    <= S_IDLE;
      r_op    <= OP_WREN;
      r_nxt   <= OP_PP;
      r_addr  <= '0;
      r_len   <= '0;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_ph    <= 1'b0;
      r_gap   <= '0;
      r_polls <= '0;
      r_tmo   <= 1'b0;
      r_cs    <= 1'b1;
      r_fclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_st)
        S_IDLE: if (strt) begin
          r_addr  <= addr;
          r_len   <= len;
          r_busy  <= 1'b1;
          r_polls <= '0;
          r_tmo   <= 1'b0;
          r_st    <= S_CHECK;
        end
        S_CHECK: if (w_bad) begin
          r_done <= 1'b1;
          r_err  <= 1'b1;
          r_busy <= 1'b0;
          r_st   <= S_IDLE;
        end
        S_SHIFT: if (!r_ph) begin
          r_fclk <= 1'b1;
          r_ph   <= 1'b1;
        end else begin
          r_fclk <= 1'b0;
          r_ph   <= 1'b0;
          if (r_cnt != 6'd1) begin
            r_sr   <= r_sr << 1;
            r_mosi <= r_sr[30];
            r_cnt  <= r_cnt - 6'd1;
          end else begin
            r_mosi <= 1'b0;
            r_gap  <= 16'(CS_HIGH_CYCLES - 1);
            if (r_op == OP_PP || (r_op == OP_DATA && r_len != 9'd1)) begin
              r_st  <= S_DWAIT;
              r_rdy <= 1'b1;
            end else begin
              r_cs <= 1'b1;
              r_st <= S_GAP;
            end
            if (r_op == OP_DATA) r_len <= r_len - 9'd1;
            if (r_op == OP_WREN) r_nxt <= OP_PP;
            if (r_op == OP_DATA) r_nxt <= OP_RDSR;
            // The final bit clocked in is status[0] (WIP).
            if (r_op == OP_RDSR) begin
              r_polls <= w_poll;
              r_tmo   <= flash_MISO && (w_poll == POLL_LIMIT);
              r_nxt   <= (!flash_MISO || w_poll == POLL_LIMIT) ? OP_FIN : OP_RDSR;
            end
          end
        end
        S_GAP: if (r_gap != 16'd0) r_gap <= r_gap - 16'd1;
          else if (r_nxt == OP_FIN) begin
            r_done <= 1'b1;
            r_err  <= r_tmo;
            r_busy <= 1'b0;
            r_st   <= S_IDLE;
          end
        default: ;
      endcase
      if (w_go) begin
        r_op   <= w_op;
        r_sr   <= w_ld;
        r_mosi <= w_ld[31];
        r_cnt  <= w_ld_cnt;
        r_ph   <= 1'b0;
        r_fclk <= 1'b0;
        r_cs   <= 1'b0;
        r_rdy  <= 1'b0;
        r_st   <= S_SHIFT;
      end
    end
  end
  assign wr_ready   = r_rdy;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign flash_clk  = r_fclk;
  assign flash_MOSI = r_mosi;
  assign flash_cs   = r_cs;
endmodule

// File: tb/tb_flash_page_writer.sv
// tb_flash_page_writer: scoreboard bench; a bus monitor decodes SPI transactions and done pulses
// and checks them against expectations queued by the directed stimulus.
module tb_flash_page_writer;
  localparam int GAP = 8;
  logic clk = 0, rst = 0, strt = 0, wr_valid = 0;
  logic [23:0] addr = '0;
  logic [8:0] len = '0;
  logic [7:0] wr_data = '0;
  logic wr_ready, busy, done, err, flash_clk, flash_MOSI, flash_cs, flash_MISO;
  int n_chk = 0, n_fail = 0;
  int wip_left = 0, hs_cnt = 0, tot_hs = 0, done_cnt = 0, txn_starts = 0, rdy_cycles = 0;
  int nbits = 0, hi_cnt = 1000;
  logic prev_cs = 1, prev_clk = 0;
  logic [7:0] cur_b = '0;
  logic [7:0] cur[$];
  logic [7:0] exp_b[$];
  int exp_len[$];
  logic exp_err[$];
  int exp_hs[$];
  logic [7:0] data [256];

  assign flash_MISO = (wip_left > 0);

  flash_page_writer #(.CS_HIGH_CYCLES(GAP), .POLL_LIMIT(32'd3)) dut (
    .clk(clk), .rst(rst), .strt(strt), .addr(addr), .len(len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .busy(busy), .done(done), .err(err),
    .flash_clk(flash_clk), .flash_MOSI(flash_MOSI), .flash_cs(flash_cs), .flash_MISO(flash_MISO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic end_txn();
    int l;
    logic [7:0] b;
    if (!rst) return;
    if (cur.size() > 0 && cur[0] == 8'h05 && wip_left > 0) wip_left--;
    if (exp_len.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL txn_unexpected: got %0d bits expected no transaction", nbits);
      return;
    end
    l = exp_len.pop_front();
    chk("txn_bits", nbits, l * 8);
    for (int i = 0; i < l; i++) begin
      b = exp_b.pop_front();
      if (i < cur.size()) chk($sformatf("txn_byte[%0d]", i), {24'h0, cur[i]}, {24'h0, b});
      else begin
        n_chk++; n_fail++;
        $display("FAIL txn_byte[%0d]: got nothing expected %0h", i, b);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (wr_valid && wr_ready) hs_cnt++;
      if (wr_ready) begin
        rdy_cycles++;
        chk("rdy_bus_idle", {30'h0, flash_cs, flash_clk}, 32'h0);
      end
      if (done) begin
        done_cnt++;
        if (exp_err.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL done_unexpected: got done err=%0b expected no done", err);
        end else begin
          chk("done_err", {31'h0, err}, {31'h0, exp_err.pop_front()});
          chk("done_busy", {31'h0, busy}, 32'h0);
          chk("hs_count", hs_cnt, exp_hs.pop_front());
        end
      end
      if (prev_cs && !flash_cs) begin
        txn_starts++;
        n_chk++;
        if (hi_cnt < GAP) begin
          n_fail++;
          $display("FAIL cs_gap: got %0d high cycles expected >= %0d", hi_cnt, GAP);
        end
        nbits = 0;
        cur.delete();
      end
      if (!prev_cs && flash_cs) end_txn();
      if (!flash_cs && flash_clk && !prev_clk) begin
        cur_b = {cur_b[6:0], flash_MOSI};
        nbits++;
        if (nbits % 8 == 0) cur.push_back(cur_b);
      end
      hi_cnt = flash_cs ? hi_cnt + 1 : 0;
      prev_cs = flash_cs;
      prev_clk = flash_clk;
    end
  end

  task automatic exp_cmd(input logic [7:0] b);
    exp_len.push_back(1);
    exp_b.push_back(b);
  endtask

  task automatic exp_rdsr(input int k);
    repeat (k) begin
      exp_len.push_back(2);
      exp_b.push_back(8'h05);
      exp_b.push_back(8'h00);
    end
  endtask

  task automatic exp_pp(input logic [23:0] a, input int n);
    exp_len.push_back(4 + n);
    exp_b.push_back(8'h02);
    exp_b.push_back(a[23:16]);
    exp_b.push_back(a[15:8]);
    exp_b.push_back(a[7:0]);
    for (int i = 0; i < n; i++) exp_b.push_back(data[i]);
  endtask

  task automatic exp_done(input logic e, input int hs);
    tot_hs += hs;
    exp_err.push_back(e);
    exp_hs.push_back(tot_hs);
  endtask

  task automatic start(input logic [23:0] a, input logic [8:0] n);
    @(posedge clk); #1;
    addr = a; len = n; strt = 1;
    @(posedge clk); #1;
    strt = 0;
  endtask

  task automatic wait_done(input int d0, input int lim);
    int k = 0;
    while (done_cnt == d0 && k < lim) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == d0) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", lim);
    end
  endtask

  task automatic feed(input int n, input int stall_at);
    int k;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        repeat (50) @(posedge clk);
        #1;
      end
      wr_data = data[i];
      wr_valid = 1;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!wr_ready && k < 30000);
      if (!wr_ready) begin
        n_chk++; n_fail++;
        $display("FAIL feed_timeout: got no wr_ready for byte %0d expected handshake", i);
        wr_valid = 0;
        return;
      end
      @(posedge clk); #1;
      wr_valid = 0;
    end
  endtask

  task automatic run_op(input logic [23:0] a, input int n, input int wip, input int stall,
                        input int polls, input logic e);
    int d0;
    exp_cmd(8'h06);
    exp_pp(a, n);
    exp_rdsr(polls);
    exp_done(e, n);
    wip_left = wip;
    d0 = done_cnt;
    start(a, 9'(n));
    fork
      feed(n, stall);
      wait_done(d0, 30000);
    join
  endtask

  initial begin
    int d0, s0, r0, k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", {31'h0, flash_cs}, 32'h1);
    chk("rst_fclk", {31'h0, flash_clk}, 32'h0);
    chk("rst_mosi", {31'h0, flash_MOSI}, 32'h0);
    chk("rst_ready", {31'h0, wr_ready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    @(posedge clk); #1 rst = 1;
    repeat (12) @(posedge clk);

    data[0] = 8'hA5; data[1] = 8'h5A; data[2] = 8'h00; data[3] = 8'hFF;
    run_op(24'h000100, 4, 2, -1, 3, 1'b0);

    s0 = txn_starts; r0 = rdy_cycles; d0 = done_cnt;
    exp_done(1'b1, 0);
    start(24'h0000F0, 9'd17);
    @(negedge clk);
    chk("bad_busy", {31'h0, busy}, 32'h1);
    chk("bad_early_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    chk("bad_done", {31'h0, done}, 32'h1);
    chk("bad_err", {31'h0, err}, 32'h1);
    repeat (20) @(posedge clk);
    chk("bad_no_cs", txn_starts, s0);
    chk("bad_no_ready", rdy_cycles, r0);
    chk("bad_one_done", done_cnt, d0 + 1);

    for (int i = 0; i < 256; i++) data[i] = 8'(i * 7 + 3);
    run_op(24'h012300, 256, 0, 9, 1, 1'b0);

    data[0] = 8'h77;
    run_op(24'h000050, 1, 1000, -1, 3, 1'b1);
    wip_left = 0;

    exp_cmd(8'h06);
    s0 = txn_starts;
    start(24'h000200, 9'd2);
    k = 0;
    while (!(txn_starts == s0 + 2 && nbits >= 20) && k < 5000) begin
      @(posedge clk);
      k++;
    end
    chk("reach_pp_bit20", {31'h0, txn_starts == s0 + 2 && nbits >= 20}, 32'h1);
    #1 rst = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_cs", {31'h0, flash_cs}, 32'h1);
    chk("midrst_fclk", {31'h0, flash_clk}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_ready", {31'h0, wr_ready}, 32'h0);
    @(posedge clk); #1 rst = 1;
    repeat (10) @(posedge clk);
    data[0] = 8'h3C;
    run_op(24'h000300, 1, 0, -1, 1, 1'b0);

    data[0] = 8'h11; data[1] = 8'h22;
    exp_cmd(8'h06);
    exp_pp(24'h000010, 2);
    exp_rdsr(2);
    exp_done(1'b0, 2);
    wip_left = 1;
    d0 = done_cnt;
    start(24'h000010, 9'd2);
    fork
      feed(2, -1);
      wait_done(d0, 30000);
      begin
        repeat (60) @(posedge clk);
        #1 addr = 24'hABCDEF; len = 9'd5; strt = 1;
        @(posedge clk); #1 strt = 0;
      end
    join
    repeat (300) @(posedge clk);
    chk("repulse_one_done", done_cnt, d0 + 1);

    chk("txn_queue_empty", exp_len.size(), 0);
    chk("done_queue_empty", exp_err.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
